// File: rtl/orderbook_pkg.sv
// Shared types for the ITCH decode path: book opcodes, message-type bytes, inst_t.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
// Contents: op_t, MSG_* byte constants, inst_t, decode_op(), default field widths.
package orderbook_pkg;

  localparam int PKG_OID_W   = 64;
  localparam int PKG_PRICE_W = 32;
  localparam int PKG_QTY_W   = 32;
  localparam int TYPE_W      = 8;
  localparam int LOC_W       = 16;
  localparam int SEQ_W       = 32;
  localparam int TS_W        = 48;

  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_ADD     = 3'd1,
    OP_CANCEL  = 3'd2,
    OP_DELETE  = 3'd3,
    OP_REPLACE = 3'd4,
    OP_EXEC    = 3'd5
  } op_t;

  localparam logic [7:0] MSG_ADD      = 8'h41; // 'A'
  localparam logic [7:0] MSG_ADD_MPID = 8'h46; // 'F'
  localparam logic [7:0] MSG_CANCEL   = 8'h58; // 'X'
  localparam logic [7:0] MSG_DELETE   = 8'h44; // 'D'
  localparam logic [7:0] MSG_REPLACE  = 8'h55; // 'U'
  localparam logic [7:0] MSG_EXEC     = 8'h45; // 'E'
  localparam logic [7:0] MSG_EXEC_PX  = 8'h43; // 'C'

  typedef struct packed {
    op_t                    op;
    logic [PKG_OID_W-1:0]   order_id;
    logic [PKG_OID_W-1:0]   old_order_id;
    logic [LOC_W-1:0]       locate;
    logic                   buy_side;
    logic [PKG_PRICE_W-1:0] price;
    logic [PKG_QTY_W-1:0]   qty;
    logic [TS_W-1:0]        timestamp;
  } inst_t;

  function automatic op_t decode_op(input logic [7:0] msg_type);
    case (msg_type)
      MSG_ADD, MSG_ADD_MPID: decode_op = OP_ADD;
      MSG_CANCEL:            decode_op = OP_CANCEL;
      MSG_DELETE:            decode_op = OP_DELETE;
      MSG_REPLACE:           decode_op = OP_REPLACE;
      MSG_EXEC, MSG_EXEC_PX: decode_op = OP_EXEC;
      default:               decode_op = OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with occupancy count; head is zero while empty.
// Latency: push visible at head the cycle after the write edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
// Ports: push/push_data in, pop in, head/head_valid out, count out.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head_valid = !empty;
  assign head       = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/msg_decode_pipe.sv
// ITCH record decoder: opcode classify, locate-to-book routing, sequence check, output FIFO.
// Latency: accept at cycle N -> inst_valid at N+2 (FIFO empty); 1 record/cycle.
// Backpressure: credit based, parser_ready = fifo_count + S1 occupancy < FIFO_DEPTH.
// Ports: parser_* in (valid/ready), cfg_* locate-map write, inst/inst_book/inst_valid/inst_ready out,
//        seq_gap pulse, drop_cnt, stat_sel/stat_count.
// Build option: MSG_DECODE_STATS_EN enables per-opcode push counters on stat_count.
module msg_decode_pipe
  import orderbook_pkg::*;
#(
  parameter int OID_W      = PKG_OID_W,
  parameter int PRICE_W    = PKG_PRICE_W,
  parameter int QTY_W      = PKG_QTY_W,
  parameter int NUM_BOOKS  = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int IN_W      = 8 + 2*OID_W + 16 + 1 + PRICE_W + QTY_W + 32 + 48,
  localparam int BOOK_W    = (NUM_BOOKS > 1) ? $clog2(NUM_BOOKS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   parser_data,
  input  logic              parser_valid,
  output logic              parser_ready,
  input  logic              cfg_we,
  input  logic [BOOK_W-1:0] cfg_idx,
  input  logic [15:0]       cfg_locate,
  input  logic              cfg_en,
  output inst_t             inst,
  output logic [BOOK_W-1:0] inst_book,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              seq_gap,
  output logic [31:0]       drop_cnt,
  input  logic [2:0]        stat_sel,
  output logic [31:0]       stat_count
);

  // Field offsets inside parser_data, LSB side first.
  localparam int SEQ_LSB   = TS_W;
  localparam int QTY_LSB   = SEQ_LSB + SEQ_W;
  localparam int PRICE_LSB = QTY_LSB + QTY_W;
  localparam int BUY_BIT   = PRICE_LSB + PRICE_W;
  localparam int LOC_LSB   = BUY_BIT + 1;
  localparam int OLD_LSB   = LOC_LSB + LOC_W;
  localparam int OID_LSB   = OLD_LSB + OID_W;
  localparam int TYPE_LSB  = OID_LSB + OID_W;
  localparam int FIFO_W    = $bits(inst_t) + BOOK_W;
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

  logic              accept;
  inst_t             in_inst;
  logic [SEQ_W-1:0]  in_seq;

  logic              s1_vld;
  inst_t             s1_inst;
  logic              s1_gap;
  logic [SEQ_W-1:0]  exp_seq;
  logic              exp_seq_vld;

  logic [15:0]          map_loc [NUM_BOOKS];
  logic [NUM_BOOKS-1:0] map_en;
  logic                 hit;
  logic [BOOK_W-1:0]    hit_book;
  logic                 push;
  logic                 drop;

  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    in_flight;
  logic [FIFO_W-1:0] fifo_head;

  // Every record in S1 is guaranteed a FIFO slot, so the pipe never stalls.
  assign in_flight    = {1'b0, fifo_count} + (CNT_W+1)'(s1_vld);
  assign parser_ready = in_flight < (CNT_W+1)'(FIFO_DEPTH);
  assign accept       = parser_valid && parser_ready;

  always_comb begin
    in_inst              = '0;
    in_inst.op           = decode_op(parser_data[TYPE_LSB +: 8]);
    in_inst.order_id     = parser_data[OID_LSB +: OID_W];
    in_inst.old_order_id = (in_inst.op == OP_REPLACE) ? parser_data[OLD_LSB +: OID_W] : '0;
    in_inst.locate       = parser_data[LOC_LSB +: LOC_W];
    in_inst.buy_side     = parser_data[BUY_BIT];
    in_inst.price        = parser_data[PRICE_LSB +: PRICE_W];
    in_inst.qty          = parser_data[QTY_LSB +: QTY_W];
    in_inst.timestamp    = parser_data[0 +: TS_W];
  end
  assign in_seq = parser_data[SEQ_LSB +: SEQ_W];

  // S1: register the decoded record; the gap flag rides along to S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld      <= 1'b0;
      s1_inst     <= '0;
      s1_gap      <= 1'b0;
      exp_seq     <= '0;
      exp_seq_vld <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_inst     <= in_inst;
        s1_gap      <= exp_seq_vld && (in_seq != exp_seq);
        exp_seq     <= in_seq + 1'b1;
        exp_seq_vld <= 1'b1;
      end
    end
  end

  assign seq_gap = s1_vld && s1_gap;

  // Map writes land on the edge that ends the current lookup, so that lookup sees the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_en <= '0;
      for (int i = 0; i < NUM_BOOKS; i++) map_loc[i] <= '0;
    end else if (cfg_we && (int'(cfg_idx) < NUM_BOOKS)) begin
      map_loc[cfg_idx] <= cfg_locate;
      map_en[cfg_idx]  <= cfg_en;
    end
  end

  // S2: scan from the top so the lowest matching index is the last one assigned.
  always_comb begin
    hit      = 1'b0;
    hit_book = '0;
    for (int i = NUM_BOOKS - 1; i >= 0; i--) begin
      if (map_en[i] && (map_loc[i] == s1_inst.locate)) begin
        hit      = 1'b1;
        hit_book = BOOK_W'(i);
      end
    end
  end

  assign push = s1_vld && hit && (s1_inst.op != OP_NONE);
  assign drop = s1_vld && !push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         drop_cnt <= '0;
    else if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
  end

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  ({s1_inst, hit_book}),
    .pop        (inst_ready),
    .head       (fifo_head),
    .head_valid (inst_valid),
    .count      (fifo_count)
  );

  assign {inst, inst_book} = fifo_head;

`ifdef MSG_DECODE_STATS_EN
  logic [31:0] stat_cnt [1:5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= 5; k++) stat_cnt[k] <= '0;
      stat_count <= '0;
    end else begin
      for (int k = 1; k <= 5; k++) begin
        if (push && (s1_inst.op == op_t'(k)) && (stat_cnt[k] != '1))
          stat_cnt[k] <= stat_cnt[k] + 1'b1;
      end
      if ((stat_sel >= 3'd1) && (stat_sel <= 3'd5)) stat_count <= stat_cnt[stat_sel];
      else                                          stat_count <= '0;
    end
  end
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_count      = '0;
`endif

endmodule
